// File: rtl/pc_fetch_if.sv
// Bundle between the PC fetch unit and the datapath it feeds:
// next-PC source inputs and PC/status outputs.
interface pc_fetch_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int BRANCHSRC_WIDTH = 3,
    parameter int COUNT_WIDTH     = 32
);
    logic [BRANCHSRC_WIDTH-1:0] branch_src_in;
    logic [2:0]                 func3_in;
    logic [DATA_WIDTH-1:0]      imm_in;
    logic [DATA_WIDTH-1:0]      alu_in;
    logic [DATA_WIDTH-1:0]      reg1_in;
    logic [DATA_WIDTH-1:0]      reg2_in;
    logic                       stall_in;
    logic [DATA_WIDTH-1:0]      pc_out;
    logic [DATA_WIDTH-1:0]      pc_plus4_out;
    logic                       taken_out;
    logic                       misalign_out;
    logic                       halted_out;
    logic [COUNT_WIDTH-1:0]     instr_count_out;

    modport master (
        output branch_src_in, func3_in, imm_in, alu_in, reg1_in, reg2_in, stall_in,
        input  pc_out, pc_plus4_out, taken_out, misalign_out, halted_out, instr_count_out
    );

    modport slave (
        input  branch_src_in, func3_in, imm_in, alu_in, reg1_in, reg2_in, stall_in,
        output pc_out, pc_plus4_out, taken_out, misalign_out, halted_out, instr_count_out
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC, resolves the next PC from sequential,
// jump and branch sources, and tracks stall/halt/misalignment and retirement.
module pc_fetch_unit #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    BRANCHSRC_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = 32'h0000_0000,
    parameter int                    COUNT_WIDTH     = 32
) (
    input  logic        clk,
    input  logic        rst,
    pc_fetch_if.slave   bus
);
    localparam logic [BRANCHSRC_WIDTH-1:0] SRC_JAL  = BRANCHSRC_WIDTH'(1);
    localparam logic [BRANCHSRC_WIDTH-1:0] SRC_JALR = BRANCHSRC_WIDTH'(2);
    localparam logic [BRANCHSRC_WIDTH-1:0] SRC_BR   = BRANCHSRC_WIDTH'(3);
    localparam logic [BRANCHSRC_WIDTH-1:0] SRC_HALT = BRANCHSRC_WIDTH'(4);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [DATA_WIDTH-1:0]   pc_r, pc_nxt_s;
    logic [COUNT_WIDTH-1:0]  cnt_r, cnt_nxt_s;
    logic                    misalign_r, misalign_nxt_s;
    logic                    halted_r;
    logic [DATA_WIDTH-1:0]   pc_plus4_s;
    logic [DATA_WIDTH-1:0]   pc_plus_imm_s;
    logic [DATA_WIDTH-1:0]   target_s;
    logic                    taken_s;

    // Branch condition evaluation for the BR source, keyed by func3.
    function automatic logic br_cond_f(input logic [2:0]            f3,
                                       input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] b);
        logic res;
        case (f3)
            3'b000:  res = (a == b);
            3'b001:  res = (a != b);
            3'b100:  res = ($signed(a) <  $signed(b));
            3'b101:  res = ($signed(a) >= $signed(b));
            3'b110:  res = (a <  b);
            3'b111:  res = (a >= b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign pc_plus4_s    = pc_r + DATA_WIDTH'(4);
    assign pc_plus_imm_s = pc_r + bus.imm_in;

    // Target selection and redirect flag; redirect is suppressed outside RUN.
    always_comb begin
        target_s = pc_plus4_s;
        taken_s  = 1'b0;
        case (bus.branch_src_in)
            SRC_JAL: begin
                target_s = pc_plus_imm_s;
                taken_s  = 1'b1;
            end
            SRC_JALR: begin
                target_s = {bus.alu_in[DATA_WIDTH-1:1], 1'b0};
                taken_s  = 1'b1;
            end
            SRC_BR: begin
                if (br_cond_f(bus.func3_in, bus.reg1_in, bus.reg2_in)) begin
                    target_s = pc_plus_imm_s;
                    taken_s  = 1'b1;
                end else begin
                    target_s = pc_plus4_s;
                    taken_s  = 1'b0;
                end
            end
            default: begin
                target_s = pc_plus4_s;
                taken_s  = 1'b0;
            end
        endcase
        if (state_r != ST_RUN) begin
            taken_s = 1'b0;
        end else begin
            taken_s = taken_s;
        end
    end

    // Next-state logic: stall beats halt, halt beats the misalignment check.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        cnt_nxt_s      = cnt_r;
        misalign_nxt_s = misalign_r;
        case (state_r)
            ST_RUN: begin
                if (bus.stall_in) begin
                    state_nxt_s = ST_RUN;
                end else if (bus.branch_src_in == SRC_HALT) begin
                    cnt_nxt_s   = cnt_r + COUNT_WIDTH'(1);
                    state_nxt_s = ST_HALT;
                end else if (target_s[1:0] != 2'b00) begin
                    misalign_nxt_s = 1'b1;
                    state_nxt_s    = ST_HALT;
                end else begin
                    pc_nxt_s  = target_s;
                    cnt_nxt_s = cnt_r + COUNT_WIDTH'(1);
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_HALT;
            end
        endcase
    end

    // State, PC, counter and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            cnt_r      <= '0;
            misalign_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            cnt_r      <= cnt_nxt_s;
            misalign_r <= misalign_nxt_s;
            halted_r   <= (state_nxt_s == ST_HALT);
        end
    end

    assign bus.pc_out          = pc_r;
    assign bus.pc_plus4_out    = pc_plus4_s;
    assign bus.taken_out       = taken_s;
    assign bus.misalign_out    = misalign_r;
    assign bus.halted_out      = halted_r;
    assign bus.instr_count_out = cnt_r;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    pc_fetch_if #(.DATA_WIDTH(32), .BRANCHSRC_WIDTH(3), .COUNT_WIDTH(32)) bus ();

    pc_fetch_unit #(
        .DATA_WIDTH(32), .BRANCHSRC_WIDTH(3), .RESET_PC(32'h0000_0000), .COUNT_WIDTH(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] src, input logic [2:0] f3, input logic [31:0] imm,
                          input logic [31:0] alu, input logic [31:0] r1, input logic [31:0] r2,
                          input logic stall);
        bus.branch_src_in = src;
        bus.func3_in      = f3;
        bus.imm_in        = imm;
        bus.alu_in        = alu;
        bus.reg1_in       = r1;
        bus.reg2_in       = r2;
        bus.stall_in      = stall;
        #1;
    endtask

    task automatic do_reset();
        set_in(3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++; if (bus.pc_out !== 32'h0) begin miss_cnt++; $display("FAIL reset_pc got %h want %h", bus.pc_out, 32'h0); end
        vec_cnt++; if (bus.pc_plus4_out !== 32'h4) begin miss_cnt++; $display("FAIL reset_pc4 got %h want %h", bus.pc_plus4_out, 32'h4); end
        vec_cnt++; if (bus.halted_out !== 1'b0) begin miss_cnt++; $display("FAIL reset_halted got %b want 0", bus.halted_out); end
        vec_cnt++; if (bus.misalign_out !== 1'b0) begin miss_cnt++; $display("FAIL reset_misalign got %b want 0", bus.misalign_out); end
        vec_cnt++; if (bus.instr_count_out !== 32'd0) begin miss_cnt++; $display("FAIL reset_count got %0d want 0", bus.instr_count_out); end
        vec_cnt++; if (bus.taken_out !== 1'b0) begin miss_cnt++; $display("FAIL reset_taken got %b want 0", bus.taken_out); end
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
            step();
            vec_cnt++; if (bus.pc_out !== exp_pc[i]) begin miss_cnt++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc_out, exp_pc[i]); end
        end
        vec_cnt++; if (bus.pc_plus4_out !== 32'h10) begin miss_cnt++; $display("FAIL seq_pc4 got %h want %h", bus.pc_plus4_out, 32'h10); end
        vec_cnt++; if (bus.instr_count_out !== 32'd3) begin miss_cnt++; $display("FAIL seq_count got %0d want 3", bus.instr_count_out); end
        // reserved source behaves as SEQ without redirect
        set_in(3'd6, 3'd0, 32'h100, 32'd0, 32'd0, 32'd0, 1'b0);
        vec_cnt++; if (bus.taken_out !== 1'b0) begin miss_cnt++; $display("FAIL rsvd_taken got %b want 0", bus.taken_out); end
        step();
        vec_cnt++; if (bus.pc_out !== 32'h10) begin miss_cnt++; $display("FAIL rsvd_pc got %h want %h", bus.pc_out, 32'h10); end
    endtask

    task automatic test_branch_eq();
        do_reset();
        set_in(3'd1, 3'd0, 32'h100, 32'd0, 32'd0, 32'd0, 1'b0); step();
        set_in(3'd3, 3'd0, 32'hFFFF_FFF8, 32'd0, 32'd5, 32'd5, 1'b0);
        vec_cnt++; if (bus.taken_out !== 1'b1) begin miss_cnt++; $display("FAIL beq_taken got %b want 1", bus.taken_out); end
        step();
        vec_cnt++; if (bus.pc_out !== 32'hF8) begin miss_cnt++; $display("FAIL beq_pc got %h want %h", bus.pc_out, 32'hF8); end
        set_in(3'd1, 3'd0, 32'h8, 32'd0, 32'd0, 32'd0, 1'b0); step();
        set_in(3'd3, 3'd0, 32'hFFFF_FFF8, 32'd0, 32'd5, 32'd6, 1'b0);
        vec_cnt++; if (bus.taken_out !== 1'b0) begin miss_cnt++; $display("FAIL beq_nt_taken got %b want 0", bus.taken_out); end
        step();
        vec_cnt++; if (bus.pc_out !== 32'h104) begin miss_cnt++; $display("FAIL beq_nt_pc got %h want %h", bus.pc_out, 32'h104); end
        set_in(3'd3, 3'd1, 32'h10, 32'd0, 32'd5, 32'd6, 1'b0); step();
        vec_cnt++; if (bus.pc_out !== 32'h114) begin miss_cnt++; $display("FAIL bne_pc got %h want %h", bus.pc_out, 32'h114); end
        set_in(3'd3, 3'd2, 32'h10, 32'd0, 32'd5, 32'd5, 1'b0);
        vec_cnt++; if (bus.taken_out !== 1'b0) begin miss_cnt++; $display("FAIL f3_010_taken got %b want 0", bus.taken_out); end
        step();
        vec_cnt++; if (bus.pc_out !== 32'h118) begin miss_cnt++; $display("FAIL f3_010_pc got %h want %h", bus.pc_out, 32'h118); end
        vec_cnt++; if (bus.instr_count_out !== 32'd6) begin miss_cnt++; $display("FAIL br_count got %0d want 6", bus.instr_count_out); end
    endtask

    task automatic test_signed();
        do_reset();
        set_in(3'd1, 3'd0, 32'h40, 32'd0, 32'd0, 32'd0, 1'b0); step();
        set_in(3'd3, 3'd4, 32'h20, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0); step();
        vec_cnt++; if (bus.pc_out !== 32'h60) begin miss_cnt++; $display("FAIL blt_pc got %h want %h", bus.pc_out, 32'h60); end
        set_in(3'd1, 3'd0, 32'hFFFF_FFE0, 32'd0, 32'd0, 32'd0, 1'b0); step();
        set_in(3'd3, 3'd6, 32'h20, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0); step();
        vec_cnt++; if (bus.pc_out !== 32'h44) begin miss_cnt++; $display("FAIL bltu_pc got %h want %h", bus.pc_out, 32'h44); end
        set_in(3'd3, 3'd7, 32'h20, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0); step();
        vec_cnt++; if (bus.pc_out !== 32'h64) begin miss_cnt++; $display("FAIL bgeu_pc got %h want %h", bus.pc_out, 32'h64); end
        set_in(3'd3, 3'd5, 32'h20, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0); step();
        vec_cnt++; if (bus.pc_out !== 32'h68) begin miss_cnt++; $display("FAIL bge_pc got %h want %h", bus.pc_out, 32'h68); end
        vec_cnt++; if (bus.instr_count_out !== 32'd6) begin miss_cnt++; $display("FAIL signed_count got %0d want 6", bus.instr_count_out); end
    endtask

    task automatic test_jalr_misalign();
        do_reset();
        set_in(3'd2, 3'd0, 32'd0, 32'h2001, 32'd0, 32'd0, 1'b0); step();
        vec_cnt++; if (bus.pc_out !== 32'h2000) begin miss_cnt++; $display("FAIL jalr_pc got %h want %h", bus.pc_out, 32'h2000); end
        set_in(3'd2, 3'd0, 32'd0, 32'h10, 32'd0, 32'd0, 1'b0); step();
        set_in(3'd1, 3'd0, 32'h6, 32'd0, 32'd0, 32'd0, 1'b0);
        vec_cnt++; if (bus.taken_out !== 1'b1) begin miss_cnt++; $display("FAIL mis_taken got %b want 1", bus.taken_out); end
        step();
        vec_cnt++; if (bus.misalign_out !== 1'b1) begin miss_cnt++; $display("FAIL mis_flag got %b want 1", bus.misalign_out); end
        vec_cnt++; if (bus.halted_out !== 1'b1) begin miss_cnt++; $display("FAIL mis_halted got %b want 1", bus.halted_out); end
        vec_cnt++; if (bus.pc_out !== 32'h10) begin miss_cnt++; $display("FAIL mis_pc got %h want %h", bus.pc_out, 32'h10); end
        vec_cnt++; if (bus.instr_count_out !== 32'd2) begin miss_cnt++; $display("FAIL mis_count got %0d want 2", bus.instr_count_out); end
        for (int i = 0; i < 3; i++) begin
            set_in(3'(i), 3'd0, 32'h40, 32'h80, 32'd0, 32'd0, 1'(i == 2));
            vec_cnt++; if (bus.taken_out !== 1'b0) begin miss_cnt++; $display("FAIL halt_taken[%0d] got %b want 0", i, bus.taken_out); end
            step();
            vec_cnt++; if (bus.pc_out !== 32'h10 || bus.instr_count_out !== 32'd2 || bus.halted_out !== 1'b1)
                begin miss_cnt++; $display("FAIL halt_frozen[%0d] got pc=%h cnt=%0d h=%b want pc=10 cnt=2 h=1", i, bus.pc_out, bus.instr_count_out, bus.halted_out); end
        end
        // JALR target with bit1 set stays misaligned after bit0 clearing
        do_reset();
        set_in(3'd2, 3'd0, 32'd0, 32'h1002, 32'd0, 32'd0, 1'b0); step();
        vec_cnt++; if (bus.misalign_out !== 1'b1 || bus.pc_out !== 32'h0) begin miss_cnt++; $display("FAIL jalr_mis got mis=%b pc=%h want mis=1 pc=0", bus.misalign_out, bus.pc_out); end
    endtask

    task automatic test_stall();
        do_reset();
        set_in(3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0); step(); step();
        set_in(3'd1, 3'd0, 32'h40, 32'd0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            vec_cnt++; if (bus.taken_out !== 1'b1) begin miss_cnt++; $display("FAIL stall_taken[%0d] got %b want 1", i, bus.taken_out); end
            step();
            vec_cnt++; if (bus.pc_out !== 32'h8 || bus.instr_count_out !== 32'd2)
                begin miss_cnt++; $display("FAIL stall_hold[%0d] got pc=%h cnt=%0d want pc=8 cnt=2", i, bus.pc_out, bus.instr_count_out); end
        end
        set_in(3'd1, 3'd0, 32'h40, 32'd0, 32'd0, 32'd0, 1'b0); step();
        vec_cnt++; if (bus.pc_out !== 32'h48 || bus.instr_count_out !== 32'd3)
            begin miss_cnt++; $display("FAIL stall_release got pc=%h cnt=%0d want pc=48 cnt=3", bus.pc_out, bus.instr_count_out); end
        set_in(3'd4, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1); step();
        vec_cnt++; if (bus.halted_out !== 1'b0 || bus.instr_count_out !== 32'd3)
            begin miss_cnt++; $display("FAIL stall_vs_halt got h=%b cnt=%0d want h=0 cnt=3", bus.halted_out, bus.instr_count_out); end
    endtask

    task automatic test_halt();
        do_reset();
        set_in(3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0); step(); step();
        set_in(3'd4, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0); step();
        vec_cnt++; if (bus.halted_out !== 1'b1 || bus.pc_out !== 32'h8 || bus.instr_count_out !== 32'd3)
            begin miss_cnt++; $display("FAIL halt_req got h=%b pc=%h cnt=%0d want h=1 pc=8 cnt=3", bus.halted_out, bus.pc_out, bus.instr_count_out); end
        vec_cnt++; if (bus.misalign_out !== 1'b0) begin miss_cnt++; $display("FAIL halt_misalign got %b want 0", bus.misalign_out); end
        set_in(3'd1, 3'd0, 32'h40, 32'd0, 32'd0, 32'd0, 1'b0); step(); step();
        vec_cnt++; if (bus.pc_out !== 32'h8 || bus.instr_count_out !== 32'd3)
            begin miss_cnt++; $display("FAIL halt_hold got pc=%h cnt=%0d want pc=8 cnt=3", bus.pc_out, bus.instr_count_out); end
        rst = 1'b1; step(); rst = 1'b0;
        vec_cnt++; if (bus.pc_out !== 32'h0 || bus.halted_out !== 1'b0 || bus.instr_count_out !== 32'd0)
            begin miss_cnt++; $display("FAIL halt_rst got pc=%h h=%b cnt=%0d want pc=0 h=0 cnt=0", bus.pc_out, bus.halted_out, bus.instr_count_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_in(3'd2, 3'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0); step();
        vec_cnt++; if (bus.pc_plus4_out !== 32'h0) begin miss_cnt++; $display("FAIL wrap_pc4 got %h want 0", bus.pc_plus4_out); end
        set_in(3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0); step();
        vec_cnt++; if (bus.pc_out !== 32'h0 || bus.instr_count_out !== 32'd2)
            begin miss_cnt++; $display("FAIL wrap_pc got pc=%h cnt=%0d want pc=0 cnt=2", bus.pc_out, bus.instr_count_out); end
    endtask

    initial begin
        set_in(3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        test_reset();
        test_seq();
        test_branch_eq();
        test_signed();
        test_jalr_misalign();
        test_stall();
        test_halt();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the single-cycle datapath.
- Holds the architectural PC and drives pc/pc+4 into the datapath.
- Resolves the next PC from sequential, JAL, JALR and conditional-branch sources, using the datapath's register operands, immediate and ALU result.
- Adds stall, halt and misaligned-target detection, plus a retired-instruction counter.

Parameters:
DATA_WIDTH, 32, width of PC, operands and immediate
BRANCHSRC_WIDTH, 3, width of branch-source select
RESET_PC, 32'h0000_0000, PC value loaded on reset
COUNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
branch_src_in  input  BRANCHSRC_WIDTH  next-PC source select
func3_in  input  3  branch condition (instr[14:12])
imm_in  input  DATA_WIDTH  sign-extended immediate
alu_in  input  DATA_WIDTH  ALU result (JALR target)
reg1_in  input  DATA_WIDTH  rs1 value
reg2_in  input  DATA_WIDTH  rs2 value
stall_in  input  1  hold PC this cycle
pc_out  output  DATA_WIDTH  current PC (registered)
pc_plus4_out  output  DATA_WIDTH  pc_out + 4, combinational, wraps mod 2^DATA_WIDTH
taken_out  output  1  combinational: current cycle redirects PC
misalign_out  output  1  sticky: misaligned target detected
halted_out  output  1  unit in HALT state
instr_count_out  output  COUNT_WIDTH  retired-instruction count

Behaviour:
- Reset (rst=1 at clk edge): pc_out=RESET_PC, state=RUN, misalign_out=0, halted_out=0, instr_count_out=0. Reset overrides all other inputs, including a mid-stall or HALT state.
- Branch source select (branch_src_in):
  - 000 SEQ: target=pc+4.
  - 001 JAL: target=pc+imm_in.
  - 010 JALR: target=alu_in with bit0 cleared.
  - 011 BR: conditional, see next bullet.
  - 100 HALT request.
  - 101–111 reserved, treated as SEQ.
- Conditional branch (BR) by func3_in:
  - 000 BEQ: reg1==reg2. 001 BNE: reg1!=reg2.
  - 100 BLT: signed <. 101 BGE: signed >=.
  - 110 BLTU: unsigned <. 111 BGEU: unsigned >=.
  - 010/011: never taken.
  - If taken, target=pc+imm_in; otherwise pc+4.
- Arithmetic: all additions are modulo 2^DATA_WIDTH with no overflow flag; pc 0xFFFF_FFFC + 4 = 0x0000_0000.
- taken_out=1 in RUN for JAL, for JALR, and for BR when the condition is true; 0 otherwise, including in HALT. It is combinational and independent of stall_in.
- State machine, RUN:
  - stall_in=1: PC and counter hold; no misalign/halt check.
  - Else if branch_src=HALT: PC holds, counter +1, next state HALT.
  - Else if the selected target has bits[1:0]!=0: PC holds, counter unchanged, misalign_out set, next state HALT.
  - Else: pc <= target, counter +1.
- State machine, HALT: PC, counter and misalign_out frozen; stall_in and branch_src_in are ignored; halted_out=1. Only rst exits HALT.
- halted_out is registered and rises one cycle after the triggering edge's inputs are sampled (i.e. visible after that edge).
- Latency: next PC is visible on pc_out one clock after the edge where the inputs were sampled; single-cycle throughput.
- Counter wraps to 0 after its maximum value; no saturation.
- JALR alignment check uses the bit0-cleared target, so alu_in=0x1001 gives target 0x1000 (valid) while 0x1002 is misaligned.
- Simultaneous stall_in=1 and branch_src=HALT: the stall wins and the halt is not taken that cycle.

Test Plan:
- Reset then SEQ ×3 → pc_out 0x0, 0x4, 0x8, 0xC; pc_plus4_out=0x10; instr_count_out=3.
- pc=0x100, BR func3=000, reg1=reg2=5, imm=-8 → taken_out=1, pc_out=0xF8; repeat with reg2=6 → pc_out=0x104.
- BLT vs BLTU with reg1=0xFFFF_FFFF, reg2=1, imm=0x20, pc=0x40 → BLT taken (pc=0x60); BLTU not taken (pc=0x44).
- JALR alu_in=0x2001 → pc=0x2000; JAL imm=0x6 from pc=0x10 → misalign_out=1, halted_out=1, pc stays 0x10, count unchanged; further inputs ignored until rst.
- stall_in=1 for 2 cycles with JAL imm=0x40 → pc and count hold, taken_out=1; stall released → pc=old+0x40.
- HALT request at pc=0x8 with rst asserted 3 cycles later → count +1, pc frozen at 0x8; after rst, pc=RESET_PC, halted_out=0, count=0.
